maxpool2x2_stream: RTL and testbench

- Streaming 2x2 / stride-2 pooling unit placed after the convolutor3x3 output in the accelerator datapath.
- Consumes one raster-order pixel stream with a valid/ready handshake.
- Keeps a half-width line buffer of even-row pair maxima.
- Emits one pooled value per 2x2 window on the odd rows, with runtime image size and backpressure support.

---
 rtl/maxpool2x2_stream.sv | 133 +++++++++++++
 tb/tb_maxpool2x2_stream.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2/stride-2 pooling over a raster-order pixel stream.
// Define AVGPOOL_EN to add the mode port and per-frame average pooling.
module maxpool2x2_stream #(
   parameter int DATA_W    = 32,
   parameter int MAX_WIDTH = 128,
   parameter int DIM_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic [DIM_W-1:0]         width,
   input  logic [DIM_W-1:0]         height,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_last,
   output logic                     frame_done
`ifdef AVGPOOL_EN
   ,
   input  logic                     mode
`endif
);
   localparam int AW = $clog2(MAX_WIDTH / 2);
`ifdef AVGPOOL_EN
   localparam int LB_W = DATA_W + 1;
`else
   localparam int LB_W = DATA_W;
`endif
   logic [DIM_W-1:0] col_q, col_d, row_q, row_d, w_q, h_q, cur_w, cur_h;
   logic signed [DATA_W-1:0] pair_q, pair_d, out_data_q, out_data_d;
   logic signed [DATA_W-1:0] pair_max, lb_max, res_max, result;
   logic signed [LB_W-1:0] linebuf [MAX_WIDTH/2];
   logic signed [LB_W-1:0] lb_rd, lb_wr;
   logic out_valid_q, out_valid_d, out_last_q, out_last_d, frame_done_q, frame_done_d;
   logic beat, start, col_end, row_end, keep, emit, win_last;

   assign in_ready   = !out_valid_q || out_ready;
   assign beat       = in_valid && in_ready;
   assign start      = (col_q == '0) && (row_q == '0);
   assign cur_w      = start ? width : w_q;
   assign cur_h      = start ? height : h_q;
   assign col_end    = (cur_w == '0) || (col_q == cur_w - 1'b1);
   assign row_end    = (cur_h == '0) || (row_q == cur_h - 1'b1);
   // A pixel counts only if its whole 2x2 window lies inside the image.
   assign keep       = ({col_q[DIM_W-1:1], 1'b1} < cur_w) && ({row_q[DIM_W-1:1], 1'b1} < cur_h);
   assign emit       = beat && keep && row_q[0] && col_q[0];
   assign win_last   = ((DIM_W+1)'(col_q) + (DIM_W+1)'(2) >= (DIM_W+1)'(cur_w)) &&
                       ((DIM_W+1)'(row_q) + (DIM_W+1)'(2) >= (DIM_W+1)'(cur_h));
   assign lb_rd      = linebuf[col_q[AW:1]];
   assign lb_max     = $signed(lb_rd[DATA_W-1:0]);
   assign pair_max   = (pair_q > in_data) ? pair_q : in_data;
   assign res_max    = (lb_max > pair_max) ? lb_max : pair_max;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign frame_done = frame_done_q;

`ifdef AVGPOOL_EN
   logic mode_q, cur_mode;
   logic signed [DATA_W+1:0] sum;
   assign cur_mode = start ? mode : mode_q;
   // Average frames keep the even-row pair sum instead of its maximum.
   assign sum      = (DATA_W+2)'(lb_rd) + (DATA_W+2)'(pair_q) + (DATA_W+2)'(in_data);
   assign result   = cur_mode ? DATA_W'(sum >>> 2) : res_max;
   assign lb_wr    = cur_mode ? LB_W'(pair_q) + LB_W'(in_data) : LB_W'(pair_max);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) mode_q <= 1'b0;
      else if (beat && start) mode_q <= mode;
`else
   assign result = res_max;
   assign lb_wr  = pair_max;
`endif

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      pair_d       = pair_q;
      out_valid_d  = out_valid_q && !out_ready;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      frame_done_d = beat && col_end && row_end;
      if (beat) begin
         col_d  = col_end ? '0 : col_q + 1'b1;
         row_d  = !col_end ? row_q : (row_end ? '0 : row_q + 1'b1);
         pair_d = col_q[0] ? pair_q : in_data;
      end
      if (emit) begin
         out_valid_d = 1'b1;
         out_data_d  = result;
         out_last_d  = win_last;
      end
      if (clear) begin
         col_d        = '0;
         row_d        = '0;
         pair_d       = '0;
         out_valid_d  = 1'b0;
         out_data_d   = '0;
         out_last_d   = 1'b0;
         frame_done_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         w_q          <= '0;
         h_q          <= '0;
         pair_q       <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         pair_q       <= pair_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
         if (beat && start) begin
            w_q <= width;
            h_q <= height;
         end
      end

   always_ff @(posedge clk)
      if (beat && keep && !row_q[0] && col_q[0]) linebuf[col_q[AW:1]] <= lb_wr;
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb_maxpool2x2_stream: directed checks of maxpool2x2_stream with hand-computed results.
module tb_maxpool2x2_stream;
   logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid, out_last, frame_done;
   logic [7:0] width = 8'd4, height = 8'd4;
   logic signed [31:0] in_data = '0, out_data;
`ifdef AVGPOOL_EN
   logic mode = 1'b0;
`endif
   int n_chk = 0, n_fail = 0, stalls = 0, fd_cnt = 0;
   int stim[$], stim2[$], exp_d[$], got_d[$];
   bit exp_l[$], got_l[$];

   always #5 clk = ~clk;

   maxpool2x2_stream dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .width(width), .height(height),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .frame_done(frame_done)
`ifdef AVGPOOL_EN
      , .mode(mode)
`endif
   );

   always @(negedge clk)
      if (rst_n && out_valid && out_ready) begin
         got_d.push_back(out_data);
         got_l.push_back(out_last);
      end

   always @(negedge clk)
      if (frame_done) fd_cnt++;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input int d);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data = d;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else stalls++;
      end
      if (!ok) check("push_ready", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int w, input int h);
      width = 8'(w);
      height = 8'(h);
      foreach (stim[i]) push(stim[i]);
      in_valid = 1'b0;
   endtask

   task automatic fd_check(input string tag);
      @(negedge clk);
      check({tag, "_fd_hi"}, frame_done, 1);
      @(negedge clk);
      check({tag, "_fd_lo"}, frame_done, 0);
   endtask

   task automatic check_out(input string tag);
      check({tag, "_count"}, got_d.size(), exp_d.size());
      foreach (exp_d[i])
         if (i < got_d.size()) begin
            check($sformatf("%s_data[%0d]", tag, i), got_d[i], exp_d[i]);
            check($sformatf("%s_last[%0d]", tag, i), got_l[i], exp_l[i]);
         end
      got_d.delete();
      got_l.delete();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_frame_done", frame_done, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      // 4x4 max pooling
      stim = '{14, 1, 0, 100, 0, -1, 0, -100, 0, 0, 0, 0, 1, 2, 0, 1};
      send(4, 4);
      fd_check("max4x4");
      idle(2);
      exp_d = '{14, 100, 2, 1};
      exp_l = '{0, 0, 0, 1};
      check_out("max4x4");
`ifdef AVGPOOL_EN
      mode = 1'b1;
      send(4, 4);
      idle(3);
      exp_d = '{3, 0, 0, 0};
      exp_l = '{0, 0, 0, 1};
      check_out("avg4x4");
      stim = '{-3, -3, -3, -2};
      send(2, 2);
      idle(3);
      exp_d = '{-3};
      exp_l = '{1};
      check_out("avg_neg");
      mode = 1'b0;
`endif
      // odd 5x3 frame
      stim = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
      send(5, 3);
      fd_check("odd5x3");
      idle(2);
      exp_d = '{7, 9};
      exp_l = '{0, 1};
      check_out("odd5x3");
      // backpressure on the first result
      stim = '{14, 1, 0, 100, 0, -1, 0, -100, 0, 0, 0, 0, 1, 2, 0, 1};
      width = 8'd4;
      height = 8'd4;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(stim[i]);
      in_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", out_valid, 1);
         check("bp_data", out_data, 14);
         check("bp_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      for (int i = 6; i < 16; i++) push(stim[i]);
      idle(3);
      exp_d = '{14, 100, 2, 1};
      exp_l = '{0, 0, 0, 1};
      check_out("bp");
      // asynchronous reset mid-frame
      stim = '{500, 600, 700, 800, 900, 950};
      send(4, 4);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      got_d.delete();
      got_l.delete();
      stim = '{14, 1, 0, 100, 0, -1, 0, -100, 0, 0, 0, 0, 1, 2, 0, 1};
      send(4, 4);
      idle(3);
      exp_d = '{14, 100, 2, 1};
      exp_l = '{0, 0, 0, 1};
      check_out("midrst");
      // synchronous clear mid-frame
      stim = '{77, 77, 77};
      send(5, 3);
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      stim = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
      send(5, 3);
      fd_check("clr");
      idle(2);
      exp_d = '{7, 9};
      exp_l = '{0, 1};
      check_out("clr");
      // back-to-back frames; size changes during frame 1 only apply to frame 2
      stim = '{14, 1, 0, 100, 0, -1, 0, -100, 0, 0, 0, 0, 1, 2, 0, 1};
      stim2 = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1};
      stalls = 0;
      fd_cnt = 0;
      width = 8'd4;
      height = 8'd4;
      push(stim[0]);
      width = 8'd8;
      height = 8'd2;
      for (int i = 1; i < 16; i++) push(stim[i]);
      foreach (stim2[i]) push(stim2[i]);
      idle(3);
      check("b2b_stalls", stalls, 0);
      check("b2b_frame_done", fd_cnt, 2);
      exp_d = '{14, 100, 2, 1, 8, 6, 6, 8};
      exp_l = '{0, 0, 0, 1, 0, 0, 0, 1};
      check_out("b2b");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
